// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, performs one ready-based
// instruction-memory read per instruction and hands the word to the decoder.
// Sequence: BOOT (one idle cycle after reset) -> FETCH -> ISSUE -> FETCH ...
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  OrigPC,
    input  logic        Zero,
    input  logic [31:0] Imm,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        load;
    logic        update;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign next_pc   = {target[31:2], 2'b00};

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, memory request and the load/update strobes.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        load      = 1'b0;
        update    = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    update    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Raw next-PC target from the decoder select; code 3 behaves as PC4.
    always_comb begin
        case (OrigPC)
            2'd1:    target = Zero ? (pc + Imm) : pc_plus4;
            2'd2:    target = pc + Imm;
            default: target = pc_plus4;
        endcase
    end

    // PC, fetched instruction, valid flag and the misalignment pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            misaligned <= update && (target[1:0] != 2'b00);
            if (load) begin
                instruction <= imem_rdata;
                instr_valid <= 1'b1;
            end else if (update) begin
                pc          <= next_pc;
                instruction <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A transaction-level
// model tracks the expected PC and misalignment flag; inputs change and
// outputs are sampled on the falling clock edge.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  OrigPC = 2'd0;
    logic        Zero = 1'b0;
    logic [31:0] Imm = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc  = RESET_PC;
    logic        m_mis = 1'b0;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .OrigPC(OrigPC), .Zero(Zero), .Imm(Imm), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [1:0] o,
                                               input logic z, input logic [31:0] i);
        if (o == 2'd2 || (o == 2'd1 && z)) return p + i;
        return p + 32'd4;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Serve one fetch: wt cycles of not-ready (random garbage data), then the word.
    task automatic do_fetch(input logic [31:0] w, input int wt);
        for (int k = 0; k < wt; k++) begin
            imem_ready = 1'b0; imem_rdata = $urandom; step();
        end
        imem_ready = 1'b1; imem_rdata = w; step();
        imem_ready = 1'b0; imem_rdata = $urandom;
    endtask

    // Release ISSUE with the given select values and advance the model.
    task automatic do_issue(input logic [1:0] o, input logic z, input logic [31:0] i);
        logic [31:0] t;
        OrigPC = o; Zero = z; Imm = i; stall = 1'b0;
        t = ref_target(m_pc, o, z, i);
        step();
        m_mis = (t[1:0] != 2'b00);
        m_pc  = {t[31:2], 2'b00};
    endtask

    task automatic goto_pc(input logic [31:0] a);
        do_fetch($urandom, 0);
        do_issue(2'd2, 1'b0, a - m_pc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
        checks++; if (instruction !== NOP_INSTR) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction, NOP_INSTR); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misaligned); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_to_fetch_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL boot_to_fetch_addr got %h exp %h", imem_addr, RESET_PC); end
        m_pc = RESET_PC; m_mis = 1'b0;
    endtask

    task automatic test_sequential();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_pre got %b exp 0", instr_valid); end
        do_fetch(32'h0050_0093, 0);
        checks++; if (instruction !== 32'h0050_0093) begin errors++; $display("FAIL seq_instr got %h exp 00500093", instruction); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_issue_req got %b exp 0", imem_req); end
        for (int n = 1; n <= 3; n++) begin
            do_issue(2'd0, 1'b0, $urandom);
            checks++; if (imem_addr !== 32'(4 * n)) begin errors++; $display("FAIL seq_addr got %h exp %h", imem_addr, 32'(4 * n)); end
            checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instruction !== NOP_INSTR) begin
                errors++; $display("FAIL seq_fetch_state got req=%b v=%b i=%h exp req=1 v=0 i=%h", imem_req, instr_valid, instruction, NOP_INSTR);
            end
            if (n < 3) do_fetch($urandom, 0);
        end
    endtask

    task automatic test_branch();
        goto_pc(32'h10);
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_setup got %h exp 00000010", imem_addr); end
        do_fetch($urandom, 0);
        do_issue(2'd1, 1'b1, 32'hFFFF_FFF8);
        checks++; if (imem_addr !== 32'h08) begin errors++; $display("FAIL beq_taken got %h exp 00000008", imem_addr); end
        goto_pc(32'h10);
        do_fetch($urandom, 0);
        do_issue(2'd1, 1'b0, 32'hFFFF_FFF8);
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL beq_not_taken got %h exp 00000014", imem_addr); end
        do_fetch($urandom, 0);
        do_issue(2'd3, 1'b1, 32'h100);
        checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL orig3_pc4 got %h exp 00000018", imem_addr); end
    endtask

    task automatic test_wait();
        logic [31:0] a;
        a = imem_addr;
        for (int k = 0; k < 3; k++) begin
            imem_ready = 1'b0; imem_rdata = $urandom; step();
            checks++; if (imem_addr !== a || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL wait_hold got addr=%h req=%b v=%b exp addr=%h req=1 v=0", imem_addr, imem_req, instr_valid, a);
            end
        end
        imem_ready = 1'b1; imem_rdata = 32'hCAFE_0013; step(); imem_ready = 1'b0;
        checks++; if (instruction !== 32'hCAFE_0013 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wait_load got i=%h v=%b exp i=cafe0013 v=1", instruction, instr_valid);
        end
        do_issue(2'd0, 1'b0, '0);
        step(); step();
        #2 rst = 1'b1;
        #1;
        checks++; if (pc !== RESET_PC || imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP_INSTR) begin
            errors++; $display("FAIL rst_midwait got pc=%h req=%b v=%b i=%h exp pc=%h req=0 v=0 i=%h", pc, imem_req, instr_valid, instruction, RESET_PC, NOP_INSTR);
        end
        step();
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_midwait_boot got %b exp 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++; $display("FAIL rst_midwait_fetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        m_pc = RESET_PC; m_mis = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] w;
        logic [31:0] imm;
        goto_pc(32'h40);
        w = $urandom;
        do_fetch(w, 1);
        for (int k = 0; k < 4; k++) begin
            stall = 1'b1; OrigPC = 2'($urandom); Zero = 1'($urandom); Imm = $urandom;
            step();
            checks++; if (pc !== m_pc || instruction !== w || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold got pc=%h i=%h v=%b req=%b exp pc=%h i=%h v=1 req=0", pc, instruction, instr_valid, imem_req, m_pc, w);
            end
        end
        imm = 32'h0000_0100;
        do_issue(2'd2, 1'b0, imm);
        checks++; if (imem_addr !== 32'h140) begin errors++; $display("FAIL stall_release got %h exp 00000140", imem_addr); end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 00000000", pc_plus4); end
        do_fetch($urandom, 0);
        do_issue(2'd0, 1'b0, '0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_fetch got %h exp 00000000", imem_addr); end
        goto_pc(32'h20);
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_aligned_quiet got %b exp 0", misaligned); end
        do_fetch($urandom, 0);
        do_issue(2'd2, 1'b0, 32'd6);
        checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL mis_addr got %h exp 00000024", imem_addr); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misaligned); end
        step();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b exp 0", misaligned); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            do_fetch(w, int'($urandom_range(0, 3)));
            checks++; if (instruction !== w || instr_valid !== 1'b1 || pc !== m_pc) begin
                errors++; $display("FAIL rnd_issue got i=%h v=%b pc=%h exp i=%h v=1 pc=%h", instruction, instr_valid, pc, w, m_pc);
            end
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                stall = 1'b1; OrigPC = 2'($urandom); Imm = $urandom; step();
            end
            do_issue(2'($urandom), 1'($urandom), 32'(int'($urandom_range(0, 128)) - 64));
            checks++; if (imem_addr !== m_pc || misaligned !== m_mis || pc_plus4 !== m_pc + 32'd4 || instruction !== NOP_INSTR) begin
                errors++; $display("FAIL rnd_next got addr=%h mis=%b p4=%h i=%h exp addr=%h mis=%b p4=%h i=%h",
                                   imem_addr, misaligned, pc_plus4, instruction, m_pc, m_mis, m_pc + 32'd4, NOP_INSTR);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait();
        test_stall();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
